// File: rtl/alu_serial_pkg.sv
// Shared definitions for the digit-serial ALU: opcodes, FSM states, helpers.
package alu_defs;

    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only ADD and SUB use the carry chain and report carry/overflow.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// DIGIT-bit combinational ALU slice; the serial top feeds it one digit per cycle.
module alu_slice
    import alu_defs::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             carryin,
    input  logic [2:0]       control,
    output logic [DIGIT-1:0] out,
    output logic             carryout,
    output logic             carry_into_msb_of_digit
);

    logic [DIGIT-1:0] b_eff;
    logic             c;

    // Ripple through the digit; logic ops and illegal codes keep the carry at 0.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        b_eff                   = (control == ALU_SUB) ? ~b : b;
        c                       = is_arith(control) ? carryin : 1'b0;
        out                     = '0;
        carry_into_msb_of_digit = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            // The value left after the final iteration is the carry into the digit MSB.
            carry_into_msb_of_digit = c;
            case (control)
                ALU_ADD, ALU_SUB: begin
                    out[i] = a[i] ^ b_eff[i] ^ c;
                    c      = (a[i] & b_eff[i]) | (a[i] & c) | (b_eff[i] & c);
                end
                ALU_AND: out[i] = a[i] & b[i];
                ALU_OR:  out[i] = a[i] | b[i];
                ALU_NOR: out[i] = ~(a[i] | b[i]);
                ALU_XOR: out[i] = a[i] ^ b[i];
                default: out[i] = 1'b0;
            endcase
        end
        carryout = c;
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: latches operands, runs WIDTH/DIGIT slice steps, presents
// the result and flags behind valid/ready handshakes.
module alu_serial
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NUM_STEPS = WIDTH / DIGIT;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    logic [DIGIT-1:0] slice_out;
    logic             slice_co;
    logic             slice_cim;
    logic [WIDTH-1:0] res_shift;
    logic             accept;

    alu_slice #(.DIGIT(DIGIT)) u_slice (
        .a                       (a_q[DIGIT-1:0]),
        .b                       (b_q[DIGIT-1:0]),
        .carryin                 (carry_q),
        .control                 (op_q),
        .out                     (slice_out),
        .carryout                (slice_co),
        .carry_into_msb_of_digit (slice_cim)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;

        // Result digits enter at the top, so after NUM_STEPS the word is aligned.
        res_shift                    = res_q >> DIGIT;
        res_shift[WIDTH-1 -: DIGIT]  = slice_out;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift;
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d    = ST_DONE;
                    carryout_d = is_arith(op_q) & slice_co;
                    overflow_d = is_arith(op_q) & (slice_cim ^ slice_co);
                    zero_d     = (res_shift == '0);
                    negative_d = res_shift[WIDTH-1];
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Consumer acceptance doubles as admission of the next operation.
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = ST_IDLE;
                    accept  = in_valid;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            a_d     = A;
            b_d     = B;
            op_d    = control;
            carry_d = (control == ALU_SUB);
            cnt_d   = '0;
            state_d = ST_RUN;
        end
    end

    // State, datapath and flag registers; reset clears everything so no output is X.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign out      = res_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign negative = negative_q;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: one DIGIT=1 and one DIGIT=4 instance.
module tb_alu_serial;
    import alu_defs::*;

    typedef struct packed {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] a_in      [2];
    logic [31:0] b_in      [2];
    logic [2:0]  ctl       [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] res       [2];
    logic        co        [2];
    logic        ov        [2];
    logic        z         [2];
    logic        n         [2];

    exp_t exp_q [2][$];
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    alu_serial #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_in[0]), .B(b_in[0]), .control(ctl[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(res[0]),
        .carryout(co[0]), .overflow(ov[0]), .zero(z[0]), .negative(n[0])
    );

    alu_serial #(.WIDTH(32), .DIGIT(4)) u_d4 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_in[1]), .B(b_in[1]), .control(ctl[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(res[1]),
        .carryout(co[1]), .overflow(ov[1]), .zero(z[1]), .negative(n[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout_or_unexpected required=event", name);
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o,
                                input logic zz, input logic nn);
        exp_t e;
        e.res = r; e.co = c; e.ov = o; e.z = zz; e.n = nn;
        return e;
    endfunction

    // Monitors: check latency on each new out_valid, data on handshake, stability while stalled.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int N = (g == 0) ? 32 : 8;
        int   cyc = 0;
        int   lat_q[$];
        bit   seen = 1'b0;
        exp_t e;

        always @(negedge clock) begin
            cyc++;
            if (!reset) begin
                seen = 1'b0;
                lat_q.delete();
            end else begin
                if (out_valid[g]) begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (lat_q.size() == 0) fail_now($sformatf("latency_unexpected%0d", g));
                        else check($sformatf("latency%0d", g), cyc, lat_q.pop_front());
                    end
                    if (exp_q[g].size() == 0) begin
                        fail_now($sformatf("result_unexpected%0d", g));
                    end else begin
                        e = out_ready[g] ? exp_q[g].pop_front() : exp_q[g][0];
                        check($sformatf("out%0d", g),      res[g], e.res);
                        check($sformatf("carryout%0d", g), 32'(co[g]), 32'(e.co));
                        check($sformatf("overflow%0d", g), 32'(ov[g]), 32'(e.ov));
                        check($sformatf("zero%0d", g),     32'(z[g]),  32'(e.z));
                        check($sformatf("negative%0d", g), 32'(n[g]),  32'(e.n));
                        if (!out_ready[g]) check($sformatf("stall_in_ready%0d", g), 32'(in_ready[g]), 32'd0);
                    end
                    if (out_ready[g]) seen = 1'b0;
                end else begin
                    seen = 1'b0;
                end
                if (in_valid[g] && in_ready[g]) lat_q.push_back(cyc + N + 1);
            end
        end
    end

    // Offer one operation and hold it until accepted; scramble inputs afterwards.
    task automatic send(input int i, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
        bit ok = 1'b0;
        exp_q[i].push_back(e);
        in_valid[i] = 1'b1;
        ctl[i]      = op;
        a_in[i]     = a;
        b_in[i]     = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (in_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clock);
        #1;
        in_valid[i] = 1'b0;
        a_in[i]     = ~a;
        b_in[i]     = ~b;
        ctl[i]      = ALU_ADD;
    endtask

    task automatic wait_drain(input int i);
        bit ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (exp_q[i].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; a_in[i] = '0; b_in[i] = '0; ctl[i] = '0; out_ready[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check("rst_in_ready",  32'(in_ready[i]),  32'd1);
            check("rst_out",       res[i],            32'd0);
            check("rst_flags",     {28'd0, co[i], ov[i], z[i], n[i]}, 32'd0);
        end
        #11 reset = 1'b1;
        @(posedge clock);
        #1;

        // Arithmetic, logic and illegal codes issued back to back.
        send(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 1, 0, 1));
        send(0, ALU_SUB, 32'd5,         32'd5,         mk(32'h0000_0000, 1, 0, 1, 0));
        send(0, ALU_SUB, 32'd0,         32'd1,         mk(32'hFFFF_FFFF, 0, 0, 0, 1));
        send(0, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, 0, 0, 0, 1));
        send(0, ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hFFF0_FFF0, 0, 0, 0, 1));
        send(0, ALU_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h000F_000F, 0, 0, 0, 0));
        send(0, ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h0FF0_0FF0, 0, 0, 0, 0));
        send(0, ALU_ADD, 32'h8000_0000, 32'h8000_0000, mk(32'h0000_0000, 1, 1, 1, 0));
        send(0, 3'd0,    32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0000, 0, 0, 1, 0));
        send(0, 3'd1,    32'h1234_5678, 32'h8765_4321, mk(32'h0000_0000, 0, 0, 1, 0));
        wait_drain(0);

        // Backpressure: stall five cycles in DONE, then retire and accept together.
        out_ready[0] = 1'b0;
        send(0, ALU_ADD, 32'h1234_5678, 32'h1111_1111, mk(32'h2345_6789, 0, 0, 0, 0));
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (out_valid[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("stall_valid_timeout");
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1;
        out_ready[0] = 1'b1;
        send(0, ALU_SUB, 32'h0000_0010, 32'h0000_0020, mk(32'hFFFF_FFF0, 0, 0, 0, 1));
        wait_drain(0);

        // Leave zero=1 so the reset check sees the flag cleared.
        send(0, 3'd0, 32'd1, 32'd2, mk(32'h0000_0000, 0, 0, 1, 0));
        wait_drain(0);

        // Asynchronous reset ten steps into RUN.
        send(0, ALU_ADD, 32'hFFFF_0000, 32'h0000_FFFF, mk(32'hFFFF_FFFF, 0, 0, 0, 1));
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("mid_rst_out",       res[0],            32'd0);
        check("mid_rst_flags",     {28'd0, co[0], ov[0], z[0], n[0]}, 32'd0);
        exp_q[0].delete();
        exp_q[1].delete();
        #6 reset = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready",  32'(in_ready[0]),  32'd1);
        check("post_rst_out_valid", 32'(out_valid[0]), 32'd0);
        @(posedge clock);
        #1;
        send(0, ALU_ADD, 32'd3, 32'd4, mk(32'd7, 0, 0, 0, 0));
        wait_drain(0);

        // DIGIT=4 instance: eight-cycle latency.
        send(1, ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1, 0, 1, 0));
        send(1, ALU_SUB, 32'd3,         32'd5,         mk(32'hFFFF_FFFE, 0, 0, 0, 1));
        send(1, ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h0FF0_0FF0, 0, 0, 0, 0));
        wait_drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised, multi-cycle, digit-serial ALU; next generation of the team's 1-bit ALU slice.
- Processes WIDTH-bit operands DIGIT bits per cycle through one combinational slice, with a registered carry between steps.
- Uses valid/ready handshakes on both sides and reports carryout, overflow, zero and negative flags.
- Used by the datapath wherever area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; legal values 1, 2, 4, 8.
- NUM_STEPS (localparam), WIDTH/DIGIT, number of compute cycles per operation.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  operand transfer offered.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  operand A, sampled on accept.
- B  in  WIDTH  operand B, sampled on accept.
- control  in  3  operation code, sampled on accept.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  result.
- carryout  out  1  carry out of the MSB (add/sub only).
- overflow  out  1  signed overflow (add/sub only).
- zero  out  1  out == 0.
- negative  out  1  out[WIDTH-1].

Behaviour:
- Opcodes:
  - 2 = ADD: A+B, carry-in 0.
  - 3 = SUB: A+~B, carry-in 1.
  - 4 = AND, 5 = OR, 6 = NOR, 7 = XOR.
  - 0 and 1 are illegal: result 0, carryout 0, overflow 0, zero 1, negative 0.
- States: IDLE, RUN, DONE.
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, step counter=0, carry register=0.
  - out=0, all flags=0, out_valid=0, in_ready=1 while in IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch A, B and control into shift registers; carry register = (control==SUB); counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the slice combines the low DIGIT bits of the A/B shift registers with the carry register.
  - The result digit is shifted into the top of the result register; A/B shift right by DIGIT; the carry register takes the slice carry out.
  - On the last step (counter==NUM_STEPS-1), record carry-into-MSB and carry-out-of-MSB, then go to DONE.
  - Logical ops still take NUM_STEPS cycles; their carry chain is forced to 0.
- Latency: if operands are accepted at clock edge k, out_valid rises after edge k+NUM_STEPS (32 cycles at WIDTH=32, DIGIT=1; 8 cycles at DIGIT=4).
- DONE:
  - out_valid=1.
  - out and all flags are held stable until the handshake completes, regardless of A/B/control changes.
  - carryout = final carry (ADD/SUB), else 0.
  - overflow = carry_into_MSB XOR carry_out (ADD/SUB), else 0.
  - zero and negative apply to every legal op.
- DONE exit:
  - On out_valid && out_ready with in_valid=0: go to IDLE.
  - in_ready = out_ready while in DONE, so the consumer's acceptance admits the next operation.
  - If out_ready && in_valid in the same cycle: retire the result and accept new operands, going DONE to RUN with no IDLE bubble.
  - out_valid falls for the duration of RUN.
- Inputs changing during RUN are ignored; only the latched copies are used.
- Reset asserted mid-RUN or in DONE aborts the operation and loses the result; after release the block is in IDLE with in_ready=1.
- No output is driven X after reset; outputs retain their last value while in IDLE.

Decomposition:
- Shared package alu_defs holds:
  - opcode constants ALU_ADD=3'd2, ALU_SUB=3'd3, ALU_AND=3'd4, ALU_OR=3'd5, ALU_NOR=3'd6, ALU_XOR=3'd7;
  - state encoding ST_IDLE, ST_RUN, ST_DONE.
- One sub-module, alu_slice:
  - DIGIT-bit combinational slice with inputs a, b, carryin, control and outputs out, carryout, carry_into_msb_of_digit.
  - It is instantiated once; the top level holds the FSM, counter, shift registers and flag logic.

Test Plan:
- ADD at WIDTH=32, DIGIT=1: A=0x7FFFFFFF, B=1. Expect out=0x80000000, overflow=1, negative=1, carryout=0, zero=0; out_valid exactly 32 cycles after accept.
- SUB: 5-5 gives out=0, zero=1, carryout=1, overflow=0. SUB 0-1 gives out=0xFFFFFFFF, carryout=0, negative=1, overflow=0.
- Logic with A=0xF0F0F0F0, B=0xFF00FF00: AND=0xF000F000, OR=0xFFF0FFF0, NOR=0x000F000F, XOR=0x0FF00FF0; carryout=0 and overflow=0 for all four. Illegal control=0 gives out=0, zero=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE: out/flags stable, in_ready=0.
  - Then assert out_ready and in_valid together: next operands accepted that edge, the next result appears 32 cycles later.
- Reset: assert reset=0 at step 10 of RUN. Expect out_valid=0 and out=0 immediately (asynchronously); after release in_ready=1, and the next ADD 3+4 gives out=7.
- DIGIT=4 build: ADD 0xFFFFFFFF+1 gives out=0, carryout=1, zero=1, overflow=0, with out_valid 8 cycles after accept.
